control_fsm: RTL and testbench

//   Multi-cycle fetch/execute controller for the 16-bit CR16-subset CPU. Sits directly upstream of
//   the special-register block: consumes its INSTR and PSR outputs, drives its instr_en/pc_en/

---
 rtl/control_fsm_pkg.sv | 97 +++++++++
 rtl/control_fsm_cond_eval.sv | 47 ++++
 rtl/control_fsm.sv | 205 ++++++++++++++++++++
 tb/tb_control_fsm.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/control_fsm_pkg.sv
// Shared definitions for the CR16-subset fetch/execute controller.
//   - opcode (instr[15:12]) and extension (instr[7:4]) encodings
//   - branch/jump condition codes (instr[11:8])
//   - PSR bit positions, shared with the special-register block
//   - mux select encodings and FSM state encodings
// LUI lives on opcode 1110; opcode 1111 is left undefined and executes as a NOP.
package control_fsm_pkg;

  // Opcodes, instr[15:12]
  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ANDI  = 4'h1;
  localparam logic [3:0] OP_ORI   = 4'h2;
  localparam logic [3:0] OP_XORI  = 4'h3;
  localparam logic [3:0] OP_SPEC  = 4'h4;  // LOAD/STOR/JAL/Jcond
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_SHIFT = 4'h8;  // LSH (R) and LSHI (I)
  localparam logic [3:0] OP_SUBI  = 4'h9;
  localparam logic [3:0] OP_CMPI  = 4'hB;
  localparam logic [3:0] OP_BCOND = 4'hC;
  localparam logic [3:0] OP_MOVI  = 4'hD;
  localparam logic [3:0] OP_LUI   = 4'hE;

  // R-type extension codes, instr[7:4] under OP_RTYPE
  localparam logic [3:0] EXT_AND  = 4'h1;
  localparam logic [3:0] EXT_OR   = 4'h2;
  localparam logic [3:0] EXT_XOR  = 4'h3;
  localparam logic [3:0] EXT_ADD  = 4'h5;
  localparam logic [3:0] EXT_SUB  = 4'h9;
  localparam logic [3:0] EXT_CMP  = 4'hB;
  localparam logic [3:0] EXT_MOV  = 4'hD;

  // Extension under OP_SHIFT selecting the register form
  localparam logic [3:0] EXT_LSH  = 4'h4;

  // Extension codes under OP_SPEC
  localparam logic [3:0] EXT_LOAD  = 4'h0;
  localparam logic [3:0] EXT_STOR  = 4'h4;
  localparam logic [3:0] EXT_JAL   = 4'h8;
  localparam logic [3:0] EXT_JCOND = 4'hC;

  // Condition codes, instr[11:8]
  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_HI = 4'h4;
  localparam logic [3:0] CC_LS = 4'h5;
  localparam logic [3:0] CC_GT = 4'h6;
  localparam logic [3:0] CC_LE = 4'h7;
  localparam logic [3:0] CC_FS = 4'h8;
  localparam logic [3:0] CC_FC = 4'h9;
  localparam logic [3:0] CC_LO = 4'hA;
  localparam logic [3:0] CC_HS = 4'hB;
  localparam logic [3:0] CC_LT = 4'hC;
  localparam logic [3:0] CC_GE = 4'hD;
  localparam logic [3:0] CC_UC = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  // PSR bit indices
  localparam int PSR_C = 0;
  localparam int PSR_L = 2;
  localparam int PSR_F = 5;
  localparam int PSR_Z = 6;
  localparam int PSR_N = 7;

  // pc_src encodings
  localparam logic [1:0] PC_SRC_INC  = 2'b00;
  localparam logic [1:0] PC_SRC_DISP = 2'b01;
  localparam logic [1:0] PC_SRC_REG  = 2'b10;

  // reg_wr_src encodings
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  // imm_ext encodings
  localparam logic [1:0] IMM_SEXT = 2'b00;
  localparam logic [1:0] IMM_ZEXT = 2'b01;
  localparam logic [1:0] IMM_HIGH = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_LATCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_LDWAIT = 3'd3,
    S_LDWB   = 3'd4,
    S_STORE  = 3'd5
  } state_e;

  // R-type ALU extensions that the datapath implements
  function automatic logic is_rtype_alu(input logic [3:0] ext);
    return (ext == EXT_AND) || (ext == EXT_OR)  || (ext == EXT_XOR) ||
           (ext == EXT_ADD) || (ext == EXT_SUB) || (ext == EXT_CMP) ||
           (ext == EXT_MOV);
  endfunction

endpackage

// File: rtl/control_fsm_cond_eval.sv
// Branch/jump condition evaluator (purely combinational).
// Ports:
//   cond  in  4   condition code from instr[11:8]
//   psr   in  16  processor status word (C,L,F,Z,N used)
//   taken out 1   condition holds
module control_fsm_cond_eval
  import control_fsm_pkg::*;
(
  input  logic [3:0]  cond,
  input  logic [15:0] psr,
  output logic        taken
);

  logic c_f, l_f, f_f, z_f, n_f;
  logic unused_psr_bits;

  assign c_f = psr[PSR_C];
  assign l_f = psr[PSR_L];
  assign f_f = psr[PSR_F];
  assign z_f = psr[PSR_Z];
  assign n_f = psr[PSR_N];

  assign unused_psr_bits = ^{psr[15:8], psr[4:3], psr[1]};

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_EQ: taken = z_f;
      CC_NE: taken = ~z_f;
      CC_CS: taken = c_f;
      CC_CC: taken = ~c_f;
      CC_HI: taken = l_f;
      CC_LS: taken = ~l_f;
      CC_GT: taken = n_f;
      CC_LE: taken = ~n_f;
      CC_FS: taken = f_f;
      CC_FC: taken = ~f_f;
      CC_LO: taken = ~l_f & ~z_f;
      CC_HS: taken = l_f | z_f;
      CC_LT: taken = ~n_f & ~z_f;
      CC_GE: taken = n_f | z_f;
      CC_UC: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle fetch/execute controller for the 16-bit CR16-subset CPU.
// Drives the special-register block strobes (instr_en, pc_en, flag enables),
// register-file, ALU-mux and memory controls from state + current instr.
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   instr, psr        instruction register and processor status inputs
//   instr_en, pc_en   load IR / load PC strobes
//   pc_src            00 PC+1, 01 PC+disp, 10 Rtarget
//   mem_addr_sel      0 PC, 1 Raddr
//   mem_wr_en         memory write strobe
//   reg_wr_en         register-file write strobe
//   reg_wr_src        00 ALU, 01 memory, 10 PC+1 link
//   alu_b_sel         0 Rsrc, 1 extended immediate
//   imm_ext           00 sext, 01 zext, 10 imm<<8
//   alu_op            ALU operation code
//   cmp_f_en, of_f_en, z_f_en   flag-group update strobes
//   state_out         current state (debug)
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic [15:0] psr,
  output logic        instr_en,
  output logic        pc_en,
  output logic [1:0]  pc_src,
  output logic        mem_addr_sel,
  output logic        mem_wr_en,
  output logic        reg_wr_en,
  output logic [1:0]  reg_wr_src,
  output logic        alu_b_sel,
  output logic [1:0]  imm_ext,
  output logic [3:0]  alu_op,
  output logic        cmp_f_en,
  output logic        of_f_en,
  output logic        z_f_en,
  output logic [2:0]  state_out
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] op, ext;
  logic       taken;
  logic       is_load, is_stor, wait_done;
  logic       unused_instr_bits;

  assign op  = instr[15:12];
  assign ext = instr[7:4];

  // Rdest/Rsrc/imm low nibble feed the datapath directly, not this block.
  assign unused_instr_bits = ^instr[3:0];

  assign is_load   = (op == OP_SPEC) && (ext == EXT_LOAD);
  assign is_stor   = (op == OP_SPEC) && (ext == EXT_STOR);
  assign wait_done = (cnt_q == CNT_LAST);

  control_fsm_cond_eval u_cond_eval (
    .cond  (instr[11:8]),
    .psr   (psr),
    .taken (taken)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; the wait counter restarts on every state change so both
  // FETCH and LDWAIT always dwell exactly MEM_LAT cycles.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = wait_done ? S_LATCH : S_FETCH;
      S_LATCH:  state_d = S_EXEC;
      S_EXEC: begin
        if (is_load)      state_d = S_LDWAIT;
        else if (is_stor) state_d = S_STORE;
        else              state_d = S_FETCH;
      end
      S_LDWAIT: state_d = wait_done ? S_LDWB : S_LDWAIT;
      S_LDWB:   state_d = S_FETCH;
      S_STORE:  state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
    cnt_d = (state_d == state_q) ? cnt_q + 1'b1 : '0;
  end

  // Output decode; every strobe defaults low so reset (state forced to
  // FETCH) silences all of them immediately.
  always_comb begin
    instr_en     = 1'b0;
    pc_en        = 1'b0;
    pc_src       = PC_SRC_INC;
    mem_addr_sel = 1'b0;
    mem_wr_en    = 1'b0;
    reg_wr_en    = 1'b0;
    reg_wr_src   = WB_ALU;
    alu_b_sel    = 1'b0;
    imm_ext      = IMM_SEXT;
    alu_op       = 4'h0;
    cmp_f_en     = 1'b0;
    of_f_en      = 1'b0;
    z_f_en       = 1'b0;
    case (state_q)
      S_LATCH: instr_en = 1'b1;
      S_EXEC: begin
        // LOAD/STOR defer their single PC update to LDWB/STORE.
        pc_en = 1'b1;
        case (op)
          OP_RTYPE: begin
            if (is_rtype_alu(ext)) begin
              alu_op    = ext;
              reg_wr_en = (ext != EXT_CMP);
              of_f_en   = (ext == EXT_ADD) || (ext == EXT_SUB);
              cmp_f_en  = (ext == EXT_CMP);
              z_f_en    = (ext == EXT_ADD) || (ext == EXT_SUB) || (ext == EXT_CMP);
            end
          end
          OP_ADDI, OP_SUBI: begin
            alu_op    = op;
            alu_b_sel = 1'b1;
            reg_wr_en = 1'b1;
            of_f_en   = 1'b1;
            z_f_en    = 1'b1;
          end
          OP_CMPI: begin
            alu_op    = op;
            alu_b_sel = 1'b1;
            cmp_f_en  = 1'b1;
            z_f_en    = 1'b1;
          end
          OP_ANDI, OP_ORI, OP_XORI: begin
            alu_op    = op;
            alu_b_sel = 1'b1;
            imm_ext   = IMM_ZEXT;
            reg_wr_en = 1'b1;
          end
          OP_MOVI: begin
            alu_op    = op;
            alu_b_sel = 1'b1;
            reg_wr_en = 1'b1;
          end
          OP_LUI: begin
            alu_op    = op;
            alu_b_sel = 1'b1;
            imm_ext   = IMM_HIGH;
            reg_wr_en = 1'b1;
          end
          OP_SHIFT: begin
            if (ext == EXT_LSH) begin
              alu_op    = ext;
              reg_wr_en = 1'b1;
            end else if (ext[3:1] == 3'b000) begin
              // LSHI: ext[0] carries the shift direction, amount in imm.
              alu_op    = op;
              alu_b_sel = 1'b1;
              reg_wr_en = 1'b1;
            end
          end
          OP_SPEC: begin
            case (ext)
              EXT_LOAD, EXT_STOR: pc_en = 1'b0;
              EXT_JAL: begin
                reg_wr_en  = 1'b1;
                reg_wr_src = WB_LINK;
                pc_src     = PC_SRC_REG;
              end
              EXT_JCOND: pc_src = taken ? PC_SRC_REG : PC_SRC_INC;
              default: ;
            endcase
          end
          OP_BCOND: pc_src = taken ? PC_SRC_DISP : PC_SRC_INC;
          default: ;
        endcase
      end
      S_LDWAIT: mem_addr_sel = 1'b1;
      S_LDWB: begin
        reg_wr_en  = 1'b1;
        reg_wr_src = WB_MEM;
        pc_en      = 1'b1;
      end
      S_STORE: begin
        mem_addr_sel = 1'b1;
        mem_wr_en    = 1'b1;
        pc_en        = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;

  typedef struct packed {
    logic       instr_en;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       mem_addr_sel;
    logic       mem_wr_en;
    logic       reg_wr_en;
    logic [1:0] reg_wr_src;
    logic       alu_b_sel;
    logic [1:0] imm_ext;
    logic [3:0] alu_op;
    logic       cmp_f_en;
    logic       of_f_en;
    logic       z_f_en;
  } ctl_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] instr1 = '0, psr1 = '0, instr3 = '0, psr3 = '0;
  ctl_t obs1, obs3;
  logic [2:0] st1, st3;

  control_fsm #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .instr(instr1), .psr(psr1),
    .instr_en(obs1.instr_en), .pc_en(obs1.pc_en), .pc_src(obs1.pc_src),
    .mem_addr_sel(obs1.mem_addr_sel), .mem_wr_en(obs1.mem_wr_en),
    .reg_wr_en(obs1.reg_wr_en), .reg_wr_src(obs1.reg_wr_src),
    .alu_b_sel(obs1.alu_b_sel), .imm_ext(obs1.imm_ext), .alu_op(obs1.alu_op),
    .cmp_f_en(obs1.cmp_f_en), .of_f_en(obs1.of_f_en), .z_f_en(obs1.z_f_en),
    .state_out(st1)
  );

  control_fsm #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .instr(instr3), .psr(psr3),
    .instr_en(obs3.instr_en), .pc_en(obs3.pc_en), .pc_src(obs3.pc_src),
    .mem_addr_sel(obs3.mem_addr_sel), .mem_wr_en(obs3.mem_wr_en),
    .reg_wr_en(obs3.reg_wr_en), .reg_wr_src(obs3.reg_wr_src),
    .alu_b_sel(obs3.alu_b_sel), .imm_ext(obs3.imm_ext), .alu_op(obs3.alu_op),
    .cmp_f_en(obs3.cmp_f_en), .of_f_en(obs3.of_f_en), .z_f_en(obs3.z_f_en),
    .state_out(st3)
  );

  logic [3:0]  ce_cond = '0;
  logic [15:0] ce_psr = '0;
  logic        ce_taken;

  control_fsm_cond_eval u_ce (.cond(ce_cond), .psr(ce_psr), .taken(ce_taken));

  int n_checks = 0;
  int n_errors = 0;
  ctl_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Condition table indexed by cond code, built straight from the flag rules.
  function automatic logic ref_taken(input logic [3:0] c, input logic [15:0] p);
    logic cf, lf, ff, zf, nf;
    logic [15:0] tbl;
    cf = p[0]; lf = p[2]; ff = p[5]; zf = p[6]; nf = p[7];
    tbl = {1'b0, 1'b1, nf | zf, ~nf & ~zf, lf | zf, ~lf & ~zf, ~ff, ff,
           ~nf, nf, ~lf, lf, ~cf, cf, ~zf, zf};
    return tbl[c];
  endfunction

  // Expected EXEC-cycle controls for non-memory instructions.
  function automatic ctl_t exec_vec(input logic [15:0] ins, input logic [15:0] p);
    ctl_t v;
    logic [3:0] op, ext, k;
    logic alu_r, alu_i;
    op  = ins[15:12];
    ext = ins[7:4];
    v = '0;
    v.pc_en = 1'b1;
    alu_r = ((op == 4'h0) && (ext inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD})) ||
            ((op == 4'h8) && (ext == 4'h4));
    alu_i = (op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hE}) ||
            ((op == 4'h8) && (ext[3:1] == 3'b000));
    if (alu_r || alu_i) begin
      k = alu_r ? ext : op;
      v.alu_op    = k;
      v.alu_b_sel = alu_i;
      v.reg_wr_en = (k != 4'hB);
      v.of_f_en   = (k == 4'h5) || (k == 4'h9);
      v.cmp_f_en  = (k == 4'hB);
      v.z_f_en    = v.of_f_en || v.cmp_f_en;
      if (alu_i && (op inside {4'h1, 4'h2, 4'h3})) v.imm_ext = 2'b01;
      if (alu_i && (op == 4'hE)) v.imm_ext = 2'b10;
    end else if (op == 4'h4 && ext == 4'h8) begin
      v.reg_wr_en  = 1'b1;
      v.reg_wr_src = 2'b10;
      v.pc_src     = 2'b10;
    end else if (op == 4'h4 && ext == 4'hC) begin
      v.pc_src = ref_taken(ins[11:8], p) ? 2'b10 : 2'b00;
    end else if (op == 4'hC) begin
      v.pc_src = ref_taken(ins[11:8], p) ? 2'b01 : 2'b00;
    end
    return v;
  endfunction

  // Whole per-cycle trace of one instruction, from first fetch cycle.
  task automatic build_trace(input int lat, input logic [15:0] ins, input logic [15:0] p);
    ctl_t z, v;
    z = '0;
    exp_q.delete();
    repeat (lat) exp_q.push_back(z);
    v = z; v.instr_en = 1'b1; exp_q.push_back(v);
    if (ins[15:12] == 4'h4 && ins[7:4] == 4'h0) begin
      exp_q.push_back(z);
      repeat (lat) begin v = z; v.mem_addr_sel = 1'b1; exp_q.push_back(v); end
      v = z; v.reg_wr_en = 1'b1; v.reg_wr_src = 2'b01; v.pc_en = 1'b1;
      exp_q.push_back(v);
    end else if (ins[15:12] == 4'h4 && ins[7:4] == 4'h4) begin
      exp_q.push_back(z);
      v = z; v.mem_addr_sel = 1'b1; v.mem_wr_en = 1'b1; v.pc_en = 1'b1;
      exp_q.push_back(v);
    end else begin
      exp_q.push_back(exec_vec(ins, p));
    end
  endtask

  // Called at a falling edge with the selected DUT in its first fetch cycle.
  task automatic run_instr(input int sel, input logic [15:0] ins, input logic [15:0] p,
                           input string tag, input int max_cyc);
    int n;
    if (sel == 1) begin instr1 = ins; psr1 = p; end
    else begin instr3 = ins; psr3 = p; end
    build_trace((sel == 1) ? 1 : 3, ins, p);
    n = exp_q.size();
    if (max_cyc >= 0 && max_cyc < n) n = max_cyc;
    for (int i = 0; i < n; i++) begin
      #1;
      check($sformatf("%s_%04h_c%0d", tag, ins, i),
            {13'd0, (sel == 1) ? obs1 : obs3}, {13'd0, exp_q[i]});
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_dut1", {13'd0, obs1}, 32'd0);
    check("rst_dut3", {13'd0, obs3}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] r_ext[7] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
    logic [3:0] i_op[8]  = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hE};
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 9))
      0: ;
      1: begin w[15:12] = 4'h0; w[7:4] = r_ext[$urandom_range(0, 6)]; end
      2: w[15:12] = i_op[$urandom_range(0, 7)];
      3: begin w[15:12] = 4'h8; if (w[6]) w[7:4] = 4'h4; else w[7:5] = 3'b000; end
      4: begin w[15:12] = 4'h4; w[7:4] = 4'h0; end
      5: begin w[15:12] = 4'h4; w[7:4] = 4'h4; end
      6: begin w[15:12] = 4'h4; w[7:4] = 4'h8; end
      7: begin w[15:12] = 4'h4; w[7:4] = 4'hC; end
      8: w[15:12] = 4'hC;
      default: w[15:12] = 4'h0;
    endcase
    return w;
  endfunction

  initial begin
    logic [15:0] p;
    do_reset();

    // MEM_LAT=1 directed
    run_instr(1, 16'h0152, 16'h0000, "add", -1);
    run_instr(1, 16'h01B2, 16'h0040, "cmp", -1);
    run_instr(1, 16'hC004, 16'h0040, "beq_t", -1);
    run_instr(1, 16'h01B2, 16'h0000, "cmp", -1);
    run_instr(1, 16'hC004, 16'h0000, "beq_nt", -1);
    run_instr(1, 16'h4E85, 16'h00E5, "jal", -1);
    run_instr(1, 16'hF0F0, 16'hFFFF, "undef", -1);
    run_instr(1, 16'hE1AB, 16'h0000, "lui", -1);
    run_instr(1, 16'h4304, 16'h0000, "load1", -1);
    for (int i = 0; i < 80; i++) run_instr(1, rand_instr(), 16'($urandom), "rnd1", -1);

    // MEM_LAT=3
    do_reset();
    run_instr(3, 16'h4304, 16'h0000, "load3", -1);
    run_instr(3, 16'h4344, 16'h0000, "stor3", -1);
    run_instr(3, 16'h0152, 16'h0000, "add3", -1);
    for (int i = 0; i < 60; i++) run_instr(3, rand_instr(), 16'($urandom), "rnd3", -1);

    // Async reset in the middle of a load wait
    run_instr(3, 16'h4304, 16'h0000, "ld_abort", 5);
    #1;
    check("ld_addr_pre", {31'd0, obs3.mem_addr_sel}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("ld_abort_rst3", {13'd0, obs3}, 32'd0);
    check("ld_abort_rst1", {13'd0, obs1}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_instr(3, 16'h0152, 16'h0000, "post_rst", -1);
    run_instr(3, 16'h4304, 16'h0000, "post_ld", -1);

    // Condition evaluator sweep
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 32; f++) begin
        p = 16'($urandom);
        p[0] = f[0]; p[2] = f[1]; p[5] = f[2]; p[6] = f[3]; p[7] = f[4];
        ce_cond = 4'(c);
        ce_psr = p;
        #1;
        check($sformatf("cond_%0d_f%0d", c, f), {31'd0, ce_taken},
              {31'd0, ref_taken(4'(c), p)});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
